res_station: RTL and testbench
==============================

# res_station

Reservation station for The Qu Processor, directly downstream of the rename stage. Holds up to `DEPTH` `res_st_cell_t` entries written by rename and snoops the common data bus (CDB) to resolve pending source tags. Issues one ready entry per cycle to the execute unit through a registered valid/ready port.

## Interface

**Parameters**
- `DEPTH`, default `2**RES_ST_ADDR_WIDTH`: number of entries. Must equal `2**RES_ST_ADDR_WIDTH`.

**Ports**
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset. Asynchronous, active-high.
- `wr_en`  in  1  rename write strobe.
- `wr_addr`  in  `res_st_addr_t`  target entry index.
- `wr_data`  in  `res_st_cell_t`  entry contents: `qj`/`vj`, `qk`/`vk`, `a`, `op`, `busy`.
- `cdb_valid`  in  1  result broadcast valid.
- `cdb_tag`  in  `res_st_addr_t`  producing entry tag.
- `cdb_data`  in  32  broadcast result.
- `flush`  in  1  synchronous flush of all entries.
- `issue_valid`  out  1  issue register holds an instruction.
- `issue_ready`  in  1  execute accepts the instruction.
- `issue_tag`  out  `res_st_addr_t`  index of the issued entry.
- `issue_op`  out  `RES_ST_OP_WIDTH`  op field.
- `issue_vj`, `issue_vk`  out  32 each  operand values.
- `issue_a`  out  32  immediate/address field.
- `full`  out  1  all entries busy.
- `occupancy`  out  `RES_ST_ADDR_WIDTH+1`  count of busy entries.
- `err_overwrite`  out  1  sticky. Set by a write to an entry that is already busy.

## Operation

- **Tags.** Tag value 0 means "operand present". A source is pending while its `q` field is nonzero.
- **Write.**
  - `wr_en` with a non-busy `wr_addr`: store `wr_data` and set `busy`.
  - `wr_en` with a busy `wr_addr`: the write is dropped and `err_overwrite` is set. It clears only on `rst`.
- **Write bypass.** If `cdb_valid` and `cdb_tag` is nonzero and equals `wr_data.qj` in the write cycle, store `vj=cdb_data`, `qj=0`. Same rule for `qk`/`vk`.
- **Snoop.** Each cycle `cdb_valid` is high with a nonzero `cdb_tag`, every busy entry whose `qj==cdb_tag` captures `vj<=cdb_data`, `qj<=0`. Same for `qk`/`vk`. Tag 0 broadcasts are ignored.
- **Ready.** An entry is ready when `busy && qj==0 && qk==0`.
- **Select.** Lowest-index ready entry, unless the age-priority option is enabled (see Configuration).
- **Issue register.** Loads when `!issue_valid || issue_ready`.
  - If an entry is selected: copy its `op`/`vj`/`vk`/`a`/index into the issue register, set `issue_valid`, and clear that entry's `busy` on the same edge.
  - If no entry is selected: `issue_valid<=0`.
  - While `issue_valid && !issue_ready`, the issue register and all entries hold, except for snoop updates.
- **Flush.** Clears every `busy` and `issue_valid` at the next edge. Flush takes priority over write, snoop and issue. Entry data fields are not cleared.
- **Full / occupancy.** `occupancy` = popcount of `busy`, registered. `full = (occupancy == DEPTH)`.
- **Reset values.** All `busy=0`; `issue_valid=0`; `issue_tag`/`issue_op`/`issue_vj`/`issue_vk`/`issue_a` = 0; `occupancy=0`; `full=0`; `err_overwrite=0`. Reset asserted mid-operation discards all entries and any pending issue.

## Timing

- Entry written at edge N with both operands present: `issue_valid` is high in cycle N+1 at the earliest. The entry is visible in cycle N, selected, and loaded at edge N+1.
- Entry resolved by a CDB broadcast sampled at edge N: selectable in cycle N, issued at edge N+1 at the earliest.
- Same-cycle write and snoop of different entries are both honoured.
- Same-cycle issue and write to the issuing index: the entry is busy at write time, so the write is dropped and `err_overwrite` is set.
- Throughput: one issue per cycle while `issue_ready` stays high and ready entries exist.
- `occupancy` reflects writes and issues with a 1-cycle lag.

## Configuration

- Macro: `QU_RS_AGE_PRIO_EN`.
- **Defined:** a `DEPTH×DEPTH` age matrix is maintained.
  - On an accepted write to entry i, i is marked younger than every currently busy entry.
  - Select picks the ready entry that has no older ready entry.
  - Flush and reset clear the matrix.
- **Undefined:** no age matrix is built and selection is the fixed lowest index.

## Test plan

- Reset, then write entry 3 with `qj=0,vj=5,qk=0,vk=7,op=2` -> `issue_valid` high one cycle after the write edge, with `issue_tag=3, issue_vj=5, issue_vk=7, issue_op=2`; `occupancy` returns to 0.
- Write entry 1 with `qj=4`, then CDB `tag=4, data=0xDEAD` -> issue with `issue_vj=0xDEAD` one cycle after the broadcast edge.
- Write entry 2 with `qk=6` in the same cycle as CDB `tag=6, data=9` -> bypass captures the value; `issue_vk=9` and the entry never stalls.
- Fill all `DEPTH` entries with pending tags -> `full=1`. A further write to busy entry 0 is dropped and sets `err_overwrite=1`.
- Hold `issue_ready=0` with 3 ready entries, then release -> issue outputs stay stable while stalled, then three consecutive issues. Order is 0,1,2, or write order when `QU_RS_AGE_PRIO_EN` is defined with writes issued in order 2,0,1.
- Assert `flush` with 4 busy entries and `issue_valid=1` -> next cycle `occupancy=0` and `issue_valid=0`. Assert `rst` mid-stall -> all outputs at reset values immediately.

Source files
------------

// File: rtl/res_station.sv
// rtl/res_station.sv - reservation station with CDB snoop and registered issue port
// Optional build macro QU_RS_AGE_PRIO_EN: oldest-ready selection via age matrix (default lowest index).
module res_station #(
    parameter int RES_ST_ADDR_WIDTH = 3,
    parameter int RES_ST_OP_WIDTH   = 4,
    parameter int DEPTH             = 2**RES_ST_ADDR_WIDTH
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          wr_en,
    input  logic [RES_ST_ADDR_WIDTH-1:0]                  wr_addr,
    input  logic [2*RES_ST_ADDR_WIDTH+RES_ST_OP_WIDTH+96:0] wr_data,
    input  logic                                          cdb_valid,
    input  logic [RES_ST_ADDR_WIDTH-1:0]                  cdb_tag,
    input  logic [31:0]                                   cdb_data,
    input  logic                                          flush,
    output logic                                          issue_valid,
    input  logic                                          issue_ready,
    output logic [RES_ST_ADDR_WIDTH-1:0]                  issue_tag,
    output logic [RES_ST_OP_WIDTH-1:0]                    issue_op,
    output logic [31:0]                                   issue_vj,
    output logic [31:0]                                   issue_vk,
    output logic [31:0]                                   issue_a,
    output logic                                          full,
    output logic [RES_ST_ADDR_WIDTH:0]                    occupancy,
    output logic                                          err_overwrite
);

    localparam int AW     = RES_ST_ADDR_WIDTH;
    localparam int OPW    = RES_ST_OP_WIDTH;
    localparam int OP_LSB = 1;
    localparam int A_LSB  = OP_LSB + OPW;
    localparam int VK_LSB = A_LSB + 32;
    localparam int QK_LSB = VK_LSB + 32;
    localparam int VJ_LSB = QK_LSB + AW;
    localparam int QJ_LSB = VJ_LSB + 32;

    // wr_data packing, MSB to LSB: {qj, vj, qk, vk, a, op, busy}; busy is implied by the write
    logic [AW-1:0]  w_qj, w_qk;
    logic [31:0]    w_vj, w_vk, w_a;
    logic [OPW-1:0] w_op;
    logic           unused_w_busy;

    assign w_qj          = wr_data[QJ_LSB +: AW];
    assign w_vj          = wr_data[VJ_LSB +: 32];
    assign w_qk          = wr_data[QK_LSB +: AW];
    assign w_vk          = wr_data[VK_LSB +: 32];
    assign w_a           = wr_data[A_LSB +: 32];
    assign w_op          = wr_data[OP_LSB +: OPW];
    assign unused_w_busy = wr_data[0];

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [AW-1:0]    qj_q [DEPTH];
    logic [AW-1:0]    qj_d [DEPTH];
    logic [AW-1:0]    qk_q [DEPTH];
    logic [AW-1:0]    qk_d [DEPTH];
    logic [31:0]      vj_q [DEPTH];
    logic [31:0]      vj_d [DEPTH];
    logic [31:0]      vk_q [DEPTH];
    logic [31:0]      vk_d [DEPTH];
    logic [31:0]      a_q  [DEPTH];
    logic [31:0]      a_d  [DEPTH];
    logic [OPW-1:0]   op_q [DEPTH];
    logic [OPW-1:0]   op_d [DEPTH];

    logic             issue_valid_q, issue_valid_d;
    logic [AW-1:0]    issue_tag_q, issue_tag_d;
    logic [OPW-1:0]   issue_op_q, issue_op_d;
    logic [31:0]      issue_vj_q, issue_vj_d;
    logic [31:0]      issue_vk_q, issue_vk_d;
    logic [31:0]      issue_a_q, issue_a_d;
    logic [AW:0]      occupancy_q, occupancy_d;
    logic             err_q, err_d;

`ifdef QU_RS_AGE_PRIO_EN
    // older_q[i] holds the set of entries that were written before entry i
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];
`endif

    logic [DEPTH-1:0] ready;
    logic             sel_found;
    logic [AW-1:0]    sel_idx;
    logic             load;
    logic             cdb_hit;
    logic [AW:0]      cnt;

    always_comb begin
        busy_d        = busy_q;
        issue_valid_d = issue_valid_q;
        issue_tag_d   = issue_tag_q;
        issue_op_d    = issue_op_q;
        issue_vj_d    = issue_vj_q;
        issue_vk_d    = issue_vk_q;
        issue_a_d     = issue_a_q;
        err_d         = err_q;
        sel_found     = 1'b0;
        sel_idx       = '0;
        cnt           = '0;
        ready         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            qj_d[i] = qj_q[i];
            qk_d[i] = qk_q[i];
            vj_d[i] = vj_q[i];
            vk_d[i] = vk_q[i];
            a_d[i]  = a_q[i];
            op_d[i] = op_q[i];
`ifdef QU_RS_AGE_PRIO_EN
            older_d[i] = older_q[i];
`endif
        end

        cdb_hit = cdb_valid && (cdb_tag != '0);

        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
        end

`ifdef QU_RS_AGE_PRIO_EN
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i] && ((older_q[i] & ready) == '0)) begin
                sel_found = 1'b1;
                sel_idx   = AW'(i);
            end
        end
`else
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_found = 1'b1;
                sel_idx   = AW'(i);
            end
        end
`endif

        for (int i = 0; i < DEPTH; i++) begin
            if (cdb_hit && busy_q[i]) begin
                if (qj_q[i] == cdb_tag) begin
                    qj_d[i] = '0;
                    vj_d[i] = cdb_data;
                end
                if (qk_q[i] == cdb_tag) begin
                    qk_d[i] = '0;
                    vk_d[i] = cdb_data;
                end
            end
        end

        load = !issue_valid_q || issue_ready;
        if (load) begin
            issue_valid_d = sel_found;
            if (sel_found) begin
                issue_tag_d     = sel_idx;
                issue_op_d      = op_q[sel_idx];
                issue_vj_d      = vj_q[sel_idx];
                issue_vk_d      = vk_q[sel_idx];
                issue_a_d       = a_q[sel_idx];
                busy_d[sel_idx] = 1'b0;
            end
        end

        // An issuing entry is still busy here, so a write to it is rejected as an overwrite
        if (wr_en && !flush) begin
            if (busy_q[wr_addr]) begin
                err_d = 1'b1;
            end else begin
                busy_d[wr_addr] = 1'b1;
                qj_d[wr_addr]   = w_qj;
                vj_d[wr_addr]   = w_vj;
                qk_d[wr_addr]   = w_qk;
                vk_d[wr_addr]   = w_vk;
                a_d[wr_addr]    = w_a;
                op_d[wr_addr]   = w_op;
                if (cdb_hit && (w_qj == cdb_tag)) begin
                    qj_d[wr_addr] = '0;
                    vj_d[wr_addr] = cdb_data;
                end
                if (cdb_hit && (w_qk == cdb_tag)) begin
                    qk_d[wr_addr] = '0;
                    vk_d[wr_addr] = cdb_data;
                end
`ifdef QU_RS_AGE_PRIO_EN
                older_d[wr_addr] = busy_q;
                for (int j = 0; j < DEPTH; j++) begin
                    older_d[j][wr_addr] = 1'b0;
                end
`endif
            end
        end

        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + (AW+1)'(busy_q[i]);
        end
        occupancy_d = cnt;

        if (flush) begin
            busy_d        = '0;
            issue_valid_d = 1'b0;
            occupancy_d   = '0;
`ifdef QU_RS_AGE_PRIO_EN
            for (int i = 0; i < DEPTH; i++) begin
                older_d[i] = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q        <= '0;
            issue_valid_q <= 1'b0;
            issue_tag_q   <= '0;
            issue_op_q    <= '0;
            issue_vj_q    <= '0;
            issue_vk_q    <= '0;
            issue_a_q     <= '0;
            occupancy_q   <= '0;
            err_q         <= 1'b0;
`ifdef QU_RS_AGE_PRIO_EN
            for (int i = 0; i < DEPTH; i++) begin
                older_q[i] <= '0;
            end
`endif
        end else begin
            busy_q        <= busy_d;
            issue_valid_q <= issue_valid_d;
            issue_tag_q   <= issue_tag_d;
            issue_op_q    <= issue_op_d;
            issue_vj_q    <= issue_vj_d;
            issue_vk_q    <= issue_vk_d;
            issue_a_q     <= issue_a_d;
            occupancy_q   <= occupancy_d;
            err_q         <= err_d;
`ifdef QU_RS_AGE_PRIO_EN
            for (int i = 0; i < DEPTH; i++) begin
                older_q[i] <= older_d[i];
            end
`endif
        end
    end

    // Entry payload is only meaningful while busy, so it needs no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            qj_q[i] <= qj_d[i];
            qk_q[i] <= qk_d[i];
            vj_q[i] <= vj_d[i];
            vk_q[i] <= vk_d[i];
            a_q[i]  <= a_d[i];
            op_q[i] <= op_d[i];
        end
    end

    assign issue_valid   = issue_valid_q;
    assign issue_tag     = issue_tag_q;
    assign issue_op      = issue_op_q;
    assign issue_vj      = issue_vj_q;
    assign issue_vk      = issue_vk_q;
    assign issue_a       = issue_a_q;
    assign occupancy     = occupancy_q;
    assign full          = (occupancy_q == (AW+1)'(DEPTH));
    assign err_overwrite = err_q;

endmodule

// File: tb/tb_res_station.sv
// tb/tb_res_station.sv - directed self-checking bench for res_station
module tb_res_station;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_en;
    logic [2:0]   wr_addr;
    logic [106:0] wr_data;
    logic         cdb_valid;
    logic [2:0]   cdb_tag;
    logic [31:0]  cdb_data;
    logic         flush;
    logic         issue_valid;
    logic         issue_ready;
    logic [2:0]   issue_tag;
    logic [3:0]   issue_op;
    logic [31:0]  issue_vj;
    logic [31:0]  issue_vk;
    logic [31:0]  issue_a;
    logic         full;
    logic [3:0]   occupancy;
    logic         err_overwrite;

    int n_asserts = 0;
    int n_fail    = 0;

    res_station dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_data      (cdb_data),
        .flush         (flush),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_tag     (issue_tag),
        .issue_op      (issue_op),
        .issue_vj      (issue_vj),
        .issue_vk      (issue_vk),
        .issue_a       (issue_a),
        .full          (full),
        .occupancy     (occupancy),
        .err_overwrite (err_overwrite)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int addr, input logic [2:0] qj, input logic [31:0] vj,
                      input logic [2:0] qk, input logic [31:0] vk,
                      input logic [31:0] a, input logic [3:0] op);
        wr_en   = 1'b1;
        wr_addr = 3'(addr);
        wr_data = {qj, vj, qk, vk, a, op, 1'b1};
        step();
        wr_en   = 1'b0;
    endtask

    logic [2:0] first_tag;
    logic [2:0] second_tag;

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; flush = 1'b0; issue_ready = 1'b1;
        step(); step();
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_full", full, 0);
        chk("rst_err", err_overwrite, 0);
        chk("rst_issue_tag", issue_tag, 0);
        chk("rst_issue_vj", issue_vj, 0);
        rst = 1'b0;
        step();

        // ready-on-write entry issues one cycle after its write edge
        wr(3, 3'd0, 32'd5, 3'd0, 32'd7, 32'h11, 4'd2);
        chk("t1_not_yet", issue_valid, 0);
        step();
        chk("t1_valid", issue_valid, 1);
        chk("t1_tag", issue_tag, 3);
        chk("t1_vj", issue_vj, 5);
        chk("t1_vk", issue_vk, 7);
        chk("t1_op", issue_op, 2);
        chk("t1_a", issue_a, 32'h11);
        step();
        chk("t1_drained", issue_valid, 0);
        step();
        chk("t1_occ", occupancy, 0);

        // pending qj resolved by a CDB broadcast
        wr(1, 3'd4, 32'd0, 3'd0, 32'd3, 32'd0, 4'd5);
        step();
        chk("t2_pending", issue_valid, 0);
        cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 32'hDEAD;
        step();
        cdb_valid = 1'b0;
        chk("t2_bcast_edge", issue_valid, 0);
        step();
        chk("t2_valid", issue_valid, 1);
        chk("t2_tag", issue_tag, 1);
        chk("t2_vj", issue_vj, 32'hDEAD);
        chk("t2_vk", issue_vk, 3);
        step();

        // write-cycle bypass of qk
        cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_data = 32'd9;
        wr(2, 3'd0, 32'd8, 3'd6, 32'd0, 32'd0, 4'd1);
        cdb_valid = 1'b0;
        step();
        chk("t3_valid", issue_valid, 1);
        chk("t3_tag", issue_tag, 2);
        chk("t3_vk", issue_vk, 9);
        chk("t3_vj", issue_vj, 8);
        step();

        // fill, overwrite error, flush
        for (int i = 0; i < 8; i++) wr(i, 3'd5, 32'd0, 3'd0, 32'd0, 32'd0, 4'd0);
        step(); step();
        chk("t4_occ_full", occupancy, 8);
        chk("t4_full", full, 1);
        chk("t4_none_ready", issue_valid, 0);
        wr(0, 3'd0, 32'd1, 3'd0, 32'd1, 32'd0, 4'd1);
        chk("t4_err", err_overwrite, 1);
        step();
        chk("t4_write_dropped", issue_valid, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t4_flush_occ", occupancy, 0);
        chk("t4_flush_full", full, 0);
        step();
        chk("t4_flush_busy_cleared", occupancy, 0);
        chk("t4_err_sticky", err_overwrite, 1);

        // stall with three ready entries, then release
        issue_ready = 1'b0;
        wr(0, 3'd0, 32'h100, 3'd0, 32'd1, 32'd0, 4'd3);
        wr(1, 3'd0, 32'h101, 3'd0, 32'd1, 32'd0, 4'd3);
        wr(2, 3'd0, 32'h102, 3'd0, 32'd1, 32'd0, 4'd3);
        chk("t5_stall_valid", issue_valid, 1);
        chk("t5_stall_tag", issue_tag, 0);
        step(); step();
        chk("t5_hold_tag", issue_tag, 0);
        chk("t5_hold_vj", issue_vj, 32'h100);
        issue_ready = 1'b1;
        step();
        chk("t5_second_tag", issue_tag, 1);
        chk("t5_second_vj", issue_vj, 32'h101);
        step();
        chk("t5_third_tag", issue_tag, 2);
        chk("t5_third_vj", issue_vj, 32'h102);
        step();
        chk("t5_done", issue_valid, 0);

        // flush with 4 busy entries and a held issue
        issue_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(i, 3'd0, 32'(i), 3'd0, 32'd0, 32'd0, 4'd0);
        step(); step();
        chk("t6_occ", occupancy, 4);
        chk("t6_valid", issue_valid, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t6_flush_valid", issue_valid, 0);
        chk("t6_flush_occ", occupancy, 0);
        issue_ready = 1'b1;
        step();
        chk("t6_entries_gone", issue_valid, 0);

        // asynchronous reset mid-stall
        issue_ready = 1'b0;
        wr(3, 3'd0, 32'h33, 3'd0, 32'd0, 32'd0, 4'd7);
        wr(6, 3'd0, 32'h66, 3'd0, 32'd0, 32'd0, 4'd7);
        chk("t7_stalled", issue_tag, 3);
        #3 rst = 1'b1;
        #1;
        chk("t7_rst_valid", issue_valid, 0);
        chk("t7_rst_tag", issue_tag, 0);
        chk("t7_rst_vj", issue_vj, 0);
        chk("t7_rst_op", issue_op, 0);
        chk("t7_rst_err", err_overwrite, 0);
        chk("t7_rst_occ", occupancy, 0);
        step();
        rst = 1'b0;
        issue_ready = 1'b1;
        step(); step();
        chk("t7_discarded", issue_valid, 0);

        // two entries become ready together: selection policy
`ifdef QU_RS_AGE_PRIO_EN
        first_tag = 3'd5; second_tag = 3'd4;
`else
        first_tag = 3'd4; second_tag = 3'd5;
`endif
        wr(5, 3'd7, 32'd0, 3'd0, 32'h55, 32'd0, 4'd1);
        wr(4, 3'd7, 32'd0, 3'd0, 32'h44, 32'd0, 4'd1);
        cdb_valid = 1'b1; cdb_tag = 3'd7; cdb_data = 32'h77;
        step();
        cdb_valid = 1'b0;
        step();
        chk("t8_first_tag", issue_tag, first_tag);
        chk("t8_first_vj", issue_vj, 32'h77);
        step();
        chk("t8_second_tag", issue_tag, second_tag);
        chk("t8_second_valid", issue_valid, 1);
        step();
        chk("t8_done", issue_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
